bit_stream_serializer: RTL and testbench
========================================

// Module: bit_stream_serializer
// PURPOSE
//  Parallel-to-serial front end for the 1011 Moore sequence detector.
//  Accepts WIDTH-bit words on a valid/ready handshake and emits them one bit per clock on sequence_out.
//  sequence_out drives the detector's sequence_in directly. Back-to-back words stream with no idle gap.
//  Between words, sequence_out holds IDLE_BIT.
// PARAMETERS
//  WIDTH      8   bits per word; legal range >= 2
//  MSB_FIRST  1   1: word_in[WIDTH-1] goes out first; 0: word_in[0] goes out first
//  IDLE_BIT   0   level driven on sequence_out while no word is being shifted
// PORTS
//  clock         in   1      rising-edge clock
//  reset         in   1      asynchronous, active-high
//  word_in       in   WIDTH  parallel word; sampled on the handshake edge only
//  word_valid    in   1      upstream has a word on word_in
//  word_ready    out  1      combinational; a word is accepted on an edge where word_valid && word_ready
//  sequence_out  out  1      registered serial bit to the detector
//  bit_valid     out  1      registered; 1 while sequence_out carries a word bit
//  word_done     out  1      registered; 1-cycle pulse coincident with the last bit of each word
//  busy          out  1      registered; equals bit_valid (state == SHIFT)
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, shift reg=0, bit_cnt=0.
//    Outputs: sequence_out=IDLE_BIT, bit_valid=0, word_done=0, busy=0.
//  State machine: two states, IDLE and SHIFT; bit_cnt is $clog2(WIDTH) bits wide.
//  IDLE:
//    word_ready=1.
//    On accept: load shift reg with word_in, put first bit on sequence_out, bit_cnt=0, go to SHIFT.
//    With no accept: stay in IDLE, sequence_out=IDLE_BIT.
//  SHIFT:
//    Each edge advances one bit and increments bit_cnt.
//    word_ready=1 only when bit_cnt==WIDTH-1 (last-bit cycle).
//  Last-bit cycle, accept taken: new word loaded; its first bit appears the next cycle.
//    State stays SHIFT; bit_valid stays 1, so there is no gap.
//  Last-bit cycle, no accept: go to IDLE; sequence_out=IDLE_BIT and bit_valid=0 next cycle.
//  Latency: handshake on edge k -> bit 0 valid in the cycle after edge k; bit i valid after edge k+i.
//  word_done is 1 in the cycle holding bit WIDTH-1, including between back-to-back words.
//  word_valid while word_ready=0: no effect; upstream must hold word_in/word_valid stable.
//  word_in changing after the accept edge has no effect on the word in flight.
//  Reset mid-word: the word in flight is discarded, with no partial completion and no word_done.
//    The first accept after reset is handled as from IDLE.
//  bit_cnt wraps to 0 on a back-to-back load; it never exceeds WIDTH-1.
// TESTING
//  T1 reset: assert reset mid-cycle with word_valid=1.
//     -> sequence_out=0, bit_valid=0, busy=0, word_done=0 immediately; word_ready=1 after release.
//  T2 single word: WIDTH=8, MSB_FIRST=1, word 8'hB0.
//     -> sequence_out = 1,0,1,1,0,0,0,0 on 8 consecutive cycles with bit_valid=1.
//     -> word_done only on the 8th cycle; then IDLE_BIT with bit_valid=0.
//  T3 back-to-back: 8'hB0 then 8'hD0, word_valid held high.
//     -> 16 contiguous valid bits 1,0,1,1,0,0,0,0,1,1,0,1,0,0,0,0.
//     -> word_ready=1 only on cycles 8 and 16; word_done on cycles 8 and 16.
//  T4 stall: word_valid held high from cycle 2 of a word.
//     -> no accept until the last-bit cycle; second word starts with no gap; no bits dropped or duplicated.
//  T5 LSB-first: MSB_FIRST=0, word 8'h0D.
//     -> sequence_out = 1,0,1,1,0,0,0,0; chained into the detector, detector_out=1 one cycle after the 4th bit.
//  T6 reset mid-word: reset after bit 3 of 8'hFF.
//     -> outputs idle immediately; no word_done; next word 8'hB0 serializes completely and correctly.

Source files
------------

// File: rtl/bit_stream_serializer.sv
// rtl/bit_stream_serializer.sv - parallel word to serial bit stream feeding the 1011 sequence detector
module bit_stream_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             sequence_out,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             seq_next;
    logic             last_bit;
    logic             accept;

    // Bit that leaves first from a word held in the shift register.
    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Word with its leading bit consumed, so the next bit moves into the lead position.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign last_bit = (state == SHIFT) && (bit_cnt == LAST_CNT);
    assign accept   = word_valid && word_ready;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave SHIFT only when the last bit goes out and no follow-on word is offered.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (last_bit && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake: a new word can be taken when idle or while the current word's last bit is on the line.
    always_comb begin
        word_ready = (state == IDLE) || last_bit;
    end

    // Datapath next values: load on accept, otherwise step through the word in flight.
    always_comb begin
        shift_next = shift_reg;
        cnt_next   = bit_cnt;
        seq_next   = IDLE_BIT;
        if (accept) begin
            shift_next = word_in;
            cnt_next   = '0;
            seq_next   = lead_bit(word_in);
        end else if (state == SHIFT && !last_bit) begin
            shift_next = advance(shift_reg);
            cnt_next   = bit_cnt + 1'b1;
            seq_next   = lead_bit(advance(shift_reg));
        end else if (state == SHIFT) begin
            cnt_next   = '0;
        end
    end

    // Registered datapath and outputs; reset drops any word in flight without a completion pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_reg    <= '0;
            bit_cnt      <= '0;
            sequence_out <= IDLE_BIT;
            bit_valid    <= 1'b0;
            word_done    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            shift_reg    <= shift_next;
            bit_cnt      <= cnt_next;
            sequence_out <= seq_next;
            bit_valid    <= (state_next == SHIFT);
            word_done    <= (state_next == SHIFT) && (cnt_next == LAST_CNT);
            busy         <= (state_next == SHIFT);
        end
    end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// tb/tb_bit_stream_serializer.sv - directed vector bench for bit_stream_serializer
module tb_bit_stream_serializer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    logic [7:0] m_word_in    = 8'h00;
    logic       m_word_valid = 1'b0;
    logic       m_word_ready;
    logic       m_seq;
    logic       m_bit_valid;
    logic       m_word_done;
    logic       m_busy;

    logic [7:0] l_word_in    = 8'h00;
    logic       l_word_valid = 1'b0;
    logic       l_word_ready;
    logic       l_seq;
    logic       l_bit_valid;
    logic       l_word_done;
    logic       l_busy;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic       v;
        logic [7:0] w;
        logic       r;
        logic       s;
        logic       bv;
        logic       d;
    } vec_t;

    vec_t vecs[$];

    always #5 clock = ~clock;

    bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
        .clock        (clock),
        .reset        (reset),
        .word_in      (m_word_in),
        .word_valid   (m_word_valid),
        .word_ready   (m_word_ready),
        .sequence_out (m_seq),
        .bit_valid    (m_bit_valid),
        .word_done    (m_word_done),
        .busy         (m_busy)
    );

    bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clock        (clock),
        .reset        (reset),
        .word_in      (l_word_in),
        .word_valid   (l_word_valid),
        .word_ready   (l_word_ready),
        .sequence_out (l_seq),
        .bit_valid    (l_bit_valid),
        .word_done    (l_word_done),
        .busy         (l_busy)
    );

    // Reference 1011 Moore detector downstream of the LSB-first serializer.
    logic [2:0] det_state;
    logic       det_out;
    assign det_out = (det_state == 3'd4);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            det_state <= 3'd0;
        end else begin
            case (det_state)
                3'd0:    det_state <= l_seq ? 3'd1 : 3'd0;
                3'd1:    det_state <= l_seq ? 3'd1 : 3'd2;
                3'd2:    det_state <= l_seq ? 3'd3 : 3'd0;
                3'd3:    det_state <= l_seq ? 3'd4 : 3'd2;
                default: det_state <= l_seq ? 3'd1 : 3'd2;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] w, input logic r, input logic s,
                       input logic bv, input logic d);
        vec_t e;
        e.v = v; e.w = w; e.r = r; e.s = s; e.bv = bv; e.d = d;
        vecs.push_back(e);
    endtask

    task automatic step_m(input logic v, input logic [7:0] w);
        @(posedge clock);
        #1;
        m_word_valid = v;
        m_word_in    = w;
        @(negedge clock);
    endtask

    initial begin
        logic [7:0] pat_b0;
        logic [7:0] pat_d0;
        logic [7:0] pat_a5;
        logic [7:0] pat_3c;
        logic [7:0] pat_lsb;

        pat_b0  = 8'b1011_0000;
        pat_d0  = 8'b1101_0000;
        pat_a5  = 8'b1010_0101;
        pat_3c  = 8'b0011_1100;
        pat_lsb = 8'b1011_0000;

        // T2: single word then idle.
        add(1'b1, 8'hB0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 8; c++) add(1'b0, 8'h00, c == 7, pat_b0[7-c], 1'b1, c == 7);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        // T3: back-to-back with word_valid held high.
        add(1'b1, 8'hB0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 8; c++) add(1'b1, 8'hD0, c == 7, pat_b0[7-c], 1'b1, c == 7);
        for (int c = 0; c < 8; c++) add(1'b0, 8'h00, c == 7, pat_d0[7-c], 1'b1, c == 7);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        // T4: second word offered from the second bit cycle onward.
        add(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b0, pat_a5[7], 1'b1, 1'b0);
        for (int c = 1; c < 8; c++) add(1'b1, 8'h3C, c == 7, pat_a5[7-c], 1'b1, c == 7);
        for (int c = 0; c < 8; c++) add(1'b0, 8'h00, c == 7, pat_3c[7-c], 1'b1, c == 7);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset state.
        @(negedge clock);
        @(negedge clock);
        chk("reset_state", {m_word_ready, m_seq, m_bit_valid, m_word_done, m_busy}, 5'b10000);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // T1: async reset mid-cycle while mid-word and word_valid high.
        step_m(1'b1, 8'hFF);
        step_m(1'b1, 8'hFF);
        chk("t1_word_started", {m_seq, m_bit_valid}, 2'b11);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("t1_reset_immediate", {m_seq, m_bit_valid, m_word_done, m_busy}, 4'b0000);
        @(posedge clock);
        #1;
        reset = 1'b0;
        m_word_valid = 1'b0;
        @(negedge clock);
        chk("t1_ready_after_release", {m_word_ready, m_bit_valid, m_busy}, 3'b100);

        // T2-T4 vector table.
        for (int i = 0; i < vecs.size(); i++) begin
            step_m(vecs[i].v, vecs[i].w);
            chk($sformatf("vec%0d", i), {m_word_ready, m_seq, m_bit_valid, m_word_done, m_busy},
                {vecs[i].r, vecs[i].s, vecs[i].bv, vecs[i].d, vecs[i].bv});
        end

        // T5: LSB-first word 0x0D into the detector.
        @(posedge clock);
        #1;
        l_word_valid = 1'b1;
        l_word_in    = 8'h0D;
        @(negedge clock);
        chk("t5_ready", l_word_ready, 1'b1);
        for (int c = 0; c < 8; c++) begin
            @(posedge clock);
            #1;
            l_word_valid = 1'b0;
            l_word_in    = 8'hFF;
            @(negedge clock);
            chk($sformatf("t5_bit%0d", c), {l_seq, l_bit_valid, l_word_done},
                {pat_lsb[7-c], 1'b1, c == 7});
            chk($sformatf("t5_det%0d", c), det_out, c == 4);
        end
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("t5_idle", {l_seq, l_bit_valid}, 2'b00);

        // T6: reset after bit 3 of 0xFF, then a clean 0xB0.
        step_m(1'b1, 8'hFF);
        for (int c = 0; c < 3; c++) begin
            step_m(1'b0, 8'h00);
            chk($sformatf("t6_bit%0d", c), {m_seq, m_bit_valid}, 2'b11);
        end
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("t6_reset_immediate", {m_seq, m_bit_valid, m_word_done, m_busy}, 4'b0000);
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            chk($sformatf("t6_quiet%0d", c), {m_word_done, m_bit_valid}, 2'b00);
            @(posedge clock);
            #1;
        end
        m_word_valid = 1'b1;
        m_word_in    = 8'hB0;
        @(negedge clock);
        chk("t6_ready", m_word_ready, 1'b1);
        for (int c = 0; c < 8; c++) begin
            step_m(1'b0, 8'h00);
            chk($sformatf("t6_b0_bit%0d", c), {m_seq, m_bit_valid, m_word_done},
                {pat_b0[7-c], 1'b1, c == 7});
        end
        step_m(1'b0, 8'h00);
        chk("t6_idle", {m_seq, m_bit_valid, m_word_done}, 3'b000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
